// File: rtl/avalon_bidir_pio_n.sv
// Bidirectional Avalon-MM PIO: per-bit direction, set/clear, open-drain option, synchronised input, edge capture, level irq.
// readdata has 1-cycle latency, pin-to-DATA latency is SYNC_STAGES+1; the slave has no waitrequest and never stalls.
module avalon_bidir_pio_n #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_OUT   = 32'hFFFF_FFFF,
    parameter int          SYNC_STAGES = 2,
    parameter bit          OPEN_DRAIN  = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    inout  wire  [WIDTH-1:0]  bidir_port
);

    localparam int WARM = SYNC_STAGES + 1;

    logic [WIDTH-1:0] out_q, dir_q, mask_q, cap_q, sel_q, prev_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync, hit, wd, clr;
    logic [2:0]       warm_cnt;
    logic             wr_en, warm_done;
    logic [31:0]      rd_mux;

    assign wd        = writedata[WIDTH-1:0];
    assign wr_en     = chipselect & ~write_n;
    assign sync      = sync_q[SYNC_STAGES-1];
    assign warm_done = (warm_cnt == 3'(WARM));
    // The chain comes out of reset at 0, so edges are ignored until it holds real samples.
    assign hit       = warm_done ? ((sel_q & ~sync & prev_q) | (~sel_q & sync & ~prev_q)) : '0;
    assign clr       = (wr_en && address == 3'd3) ? wd : '0;
    assign irq       = |(cap_q & mask_q);

    if (WIDTH < 32) begin : g_unused
        logic unused_wd_hi;
        assign unused_wd_hi = ^writedata[31:WIDTH];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        if (OPEN_DRAIN) begin : g_od
            assign bidir_port[i] = (dir_q[i] & ~out_q[i]) ? 1'b0 : 1'bz;
        end else begin : g_pp
            assign bidir_port[i] = dir_q[i] ? out_q[i] : 1'bz;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:       rd_mux[WIDTH-1:0] = sync;
            3'd1:       rd_mux[WIDTH-1:0] = dir_q;
            3'd2:       rd_mux[WIDTH-1:0] = mask_q;
            3'd3:       rd_mux[WIDTH-1:0] = cap_q;
            3'd4, 3'd5: rd_mux[WIDTH-1:0] = out_q;
            3'd6:       rd_mux[WIDTH-1:0] = sel_q;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q   <= '0;
            warm_cnt <= '0;
        end else begin
            sync_q[0] <= bidir_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync;
            if (!warm_done) warm_cnt <= warm_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q    <= RESET_OUT[WIDTH-1:0];
            dir_q    <= '0;
            mask_q   <= '0;
            cap_q    <= '0;
            sel_q    <= '0;
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
            // A capture in the same cycle as its W1C wins, so no edge is lost.
            cap_q    <= (cap_q & ~clr) | hit;
            if (wr_en) begin
                case (address)
                    3'd0:    out_q  <= wd;
                    3'd1:    dir_q  <= wd;
                    3'd2:    mask_q <= wd;
                    3'd4:    out_q  <= out_q | wd;
                    3'd5:    out_q  <= out_q & ~wd;
                    3'd6:    sel_q  <= wd;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_avalon_bidir_pio_n.sv
// Bench for avalon_bidir_pio_n: directed register table, edge/irq sequences, open-drain check, random run against a history-based model.
module tb_avalon_bidir_pio_n;

    localparam int N    = 2;
    localparam int HMAX = 4000;

    logic        clk, reset_n;
    logic [2:0]  address;
    logic        cs_pp, cs_od, write_n;
    logic [31:0] writedata;
    logic [31:0] rd_pp, rd_od;
    logic        irq_pp, irq_od;
    wire  [7:0]  pins_pp, pins_od;
    logic [7:0]  ext_pp, od_pull;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pins are recorded per clock since reset; DATA is the sample N clocks old,
    // and an edge counts only between two genuine post-reset samples.
    logic [7:0] hist [0:HMAX+1];
    int         nedge, k;
    logic [7:0] m_out, m_dir, m_mask, m_cap, m_sel, m_rd;
    logic [7:0] ms, mp, mhit, mrd, wd8;
    logic       mwe;

    avalon_bidir_pio_n #(.WIDTH(8), .RESET_OUT(32'hFFFF_FFFF), .SYNC_STAGES(N), .OPEN_DRAIN(1'b0)) u_pp (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_pp), .write_n(write_n),
        .writedata(writedata), .readdata(rd_pp), .irq(irq_pp), .bidir_port(pins_pp));

    avalon_bidir_pio_n #(.WIDTH(8), .RESET_OUT(32'hFFFF_FFFF), .SYNC_STAGES(N), .OPEN_DRAIN(1'b1)) u_od (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_od), .write_n(write_n),
        .writedata(writedata), .readdata(rd_od), .irq(irq_od), .bidir_port(pins_od));

    for (genvar i = 0; i < 8; i++) begin : g_drv
        assign pins_pp[i] = m_dir[i] ? 1'bz : ext_pp[i];
        assign pins_od[i] = od_pull[i] ? 1'b1 : 1'bz;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] h(input int j);
        return (j < 1) ? 8'h00 : hist[j];
    endfunction

    always_comb begin
        k    = nedge + 1;
        ms   = h(k - N);
        mp   = h(k - N - 1);
        mhit = 8'h00;
        if (k >= N + 2) mhit = (m_sel & ~ms & mp) | (~m_sel & ms & ~mp);
        mwe  = cs_pp & ~write_n;
        wd8  = writedata[7:0];
        case (address)
            3'd0:       mrd = ms;
            3'd1:       mrd = m_dir;
            3'd2:       mrd = m_mask;
            3'd3:       mrd = m_cap;
            3'd4, 3'd5: mrd = m_out;
            3'd6:       mrd = m_sel;
            default:    mrd = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_out <= 8'hFF; m_dir <= 8'h00; m_mask <= 8'h00; m_cap <= 8'h00; m_sel <= 8'h00;
            m_rd  <= 8'h00; nedge <= 0;
        end else begin
            m_rd     <= mrd;
            m_cap    <= (m_cap & ~((mwe && address == 3'd3) ? wd8 : 8'h00)) | mhit;
            hist[k]  <= pins_pp;
            if (nedge < HMAX) nedge <= k;
            if (mwe) begin
                case (address)
                    3'd0: m_out  <= wd8;
                    3'd1: m_dir  <= wd8;
                    3'd2: m_mask <= wd8;
                    3'd4: m_out  <= m_out | wd8;
                    3'd5: m_out  <= m_out & ~wd8;
                    3'd6: m_sel  <= wd8;
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clk_n();
        @(negedge clk);
        if (reset_n) begin
            chk("model_readdata", rd_pp, {24'h0, m_rd});
            chk("model_irq", {31'h0, irq_pp}, {31'h0, |(m_cap & m_mask)});
            chk("model_pins", {24'h0, pins_pp & m_dir}, {24'h0, m_out & m_dir});
        end
    endtask

    task automatic bus(input logic pp, input logic wr, input logic [2:0] a, input logic [31:0] d);
        cs_pp = pp; cs_od = ~pp; write_n = ~wr; address = a; writedata = d;
        clk_n();
        cs_pp = 1'b0; cs_od = 1'b0; write_n = 1'b1;
    endtask

    typedef struct packed {
        logic        wr;
        logic [2:0]  a;
        logic [31:0] d;
        logic        c;
        logic [7:0]  e;
    } vec_t;
    vec_t tbl [24];

    initial begin
        tbl[0]  = '{1'b0, 3'd0, 32'h0,     1'b1, 8'hFF};
        tbl[1]  = '{1'b0, 3'd3, 32'h0,     1'b1, 8'h00};
        tbl[2]  = '{1'b0, 3'd4, 32'h0,     1'b1, 8'hFF};
        tbl[3]  = '{1'b0, 3'd1, 32'h0,     1'b1, 8'h00};
        tbl[4]  = '{1'b0, 3'd7, 32'h0,     1'b1, 8'h00};
        tbl[5]  = '{1'b1, 3'd7, 32'h1234,  1'b0, 8'h00};
        tbl[6]  = '{1'b0, 3'd7, 32'h0,     1'b1, 8'h00};
        tbl[7]  = '{1'b1, 3'd2, 32'hFF0F,  1'b0, 8'h00};
        tbl[8]  = '{1'b0, 3'd2, 32'h0,     1'b1, 8'h0F};
        tbl[9]  = '{1'b1, 3'd2, 32'h0,     1'b0, 8'h00};
        tbl[10] = '{1'b1, 3'd6, 32'hF0,    1'b0, 8'h00};
        tbl[11] = '{1'b0, 3'd6, 32'h0,     1'b1, 8'hF0};
        tbl[12] = '{1'b1, 3'd6, 32'h0,     1'b0, 8'h00};
        tbl[13] = '{1'b1, 3'd1, 32'hFF,    1'b0, 8'h00};
        tbl[14] = '{1'b1, 3'd0, 32'hA5,    1'b0, 8'h00};
        tbl[15] = '{1'b1, 3'd4, 32'h02,    1'b0, 8'h00};
        tbl[16] = '{1'b1, 3'd5, 32'h80,    1'b0, 8'h00};
        tbl[17] = '{1'b0, 3'd0, 32'h0,     1'b1, 8'hA5};
        tbl[18] = '{1'b0, 3'd0, 32'h0,     1'b1, 8'hA7};
        tbl[19] = '{1'b0, 3'd0, 32'h0,     1'b1, 8'h27};
        tbl[20] = '{1'b0, 3'd5, 32'h0,     1'b1, 8'h27};
        tbl[21] = '{1'b0, 3'd3, 32'h0,     1'b1, 8'h02};
        tbl[22] = '{1'b1, 3'd3, 32'hFF,    1'b0, 8'h00};
        tbl[23] = '{1'b0, 3'd3, 32'h0,     1'b1, 8'h00};

        reset_n = 1'b0; cs_pp = 1'b0; cs_od = 1'b0; write_n = 1'b1; address = 3'd0;
        writedata = 32'h0; ext_pp = 8'hFF; od_pull = 8'hFF;
        repeat (3) @(negedge clk);
        chk("reset_readdata", rd_pp, 32'h0);
        chk("reset_irq", {31'h0, irq_pp}, 32'h0);
        #2 reset_n = 1'b1;
        repeat (4) clk_n();

        // Register map, set/clear and pin-to-DATA latency.
        for (int i = 0; i < 24; i++) begin
            bus(1'b1, tbl[i].wr, tbl[i].a, tbl[i].d);
            if (tbl[i].c) chk($sformatf("table_%0d", i), rd_pp, {24'h0, tbl[i].e});
            if (i == 16) chk("pins_after_clr", {24'h0, pins_pp}, 32'h27);
        end
        chk("table_irq", {31'h0, irq_pp}, 32'h0);

        // Falling-edge capture, irq and W1C.
        bus(1'b1, 1'b1, 3'd1, 32'h00);
        repeat (4) clk_n();
        bus(1'b1, 1'b1, 3'd3, 32'hFF);
        bus(1'b1, 1'b1, 3'd6, 32'h01);
        bus(1'b1, 1'b1, 3'd2, 32'h01);
        bus(1'b1, 1'b0, 3'd3, 32'h0);
        chk("cap_cleared", rd_pp, 32'h0);
        ext_pp = 8'hFE;
        for (int i = 0; i < N + 1; i++) begin
            clk_n();
            if (irq_pp) break;
        end
        chk("irq_on_fall", {31'h0, irq_pp}, 32'h1);
        bus(1'b1, 1'b0, 3'd3, 32'h0);
        chk("cap_fall", rd_pp, 32'h01);
        bus(1'b1, 1'b1, 3'd3, 32'h01);
        chk("irq_after_w1c", {31'h0, irq_pp}, 32'h0);

        // Clear lands on the same clock as a new falling edge.
        ext_pp = 8'hFF;
        repeat (4) clk_n();
        ext_pp = 8'hFE;
        clk_n();
        clk_n();
        bus(1'b1, 1'b1, 3'd3, 32'h01);
        chk("race_irq", {31'h0, irq_pp}, 32'h1);
        bus(1'b1, 1'b0, 3'd3, 32'h0);
        chk("race_cap", rd_pp, 32'h01);

        // Open-drain instance with pulled-up pins.
        bus(1'b0, 1'b1, 3'd1, 32'h01);
        bus(1'b0, 1'b1, 3'd0, 32'h01);
        repeat (3) clk_n();
        bus(1'b0, 1'b0, 3'd0, 32'h0);
        chk("od_read_high", rd_od, 32'hFF);
        chk("od_pin_high", {31'h0, pins_od[0]}, 32'h1);
        od_pull = 8'hFE;
        bus(1'b0, 1'b1, 3'd0, 32'h00);
        repeat (3) clk_n();
        chk("od_pin_low", {31'h0, pins_od[0]}, 32'h0);
        bus(1'b0, 1'b0, 3'd0, 32'h0);
        chk("od_read_low", rd_od, 32'hFE);

        // Random traffic against the model, with one asynchronous reset mid-run.
        for (int it = 0; it < 1500; it++) begin
            if (it == 600) begin
                cs_pp = 1'b1; write_n = 1'b0; address = 3'd1; writedata = 32'hFF;
                #2 reset_n = 1'b0;
                #1;
                chk("midreset_readdata", rd_pp, 32'h0);
                chk("midreset_irq", {31'h0, irq_pp}, 32'h0);
                chk("midreset_pins", {24'h0, pins_pp}, {24'h0, ext_pp});
                cs_pp = 1'b0; write_n = 1'b1;
                @(negedge clk);
                #2 reset_n = 1'b1;
            end
            cs_pp     = 1'($urandom_range(0, 1));
            write_n   = 1'($urandom_range(0, 1));
            address   = 3'($urandom_range(0, 7));
            writedata = $urandom;
            if ($urandom_range(0, 3) == 0) ext_pp = ext_pp ^ 8'($urandom);
            clk_n();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
